// File: rtl/ace_snoop_initiator.sv
// Interconnect-side ACE snoop issuer: one blocking snoop at a time over AC/CR/CD,
// returning the CR response, the assembled CD line and an error summary.
module ace_snoop_initiator #(
    parameter int AddrWidth     = 64,
    parameter int DataWidth     = 64,
    parameter int LineWidth     = 512,
    parameter int TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [3:0]           req_snoop_i,
    output logic                 ac_valid_o,
    input  logic                 ac_ready_i,
    output logic [AddrWidth-1:0] ac_addr_o,
    output logic [3:0]           ac_snoop_o,
    output logic [2:0]           ac_prot_o,
    input  logic                 cr_valid_i,
    output logic                 cr_ready_o,
    input  logic [4:0]           cr_resp_i,
    input  logic                 cd_valid_i,
    output logic                 cd_ready_o,
    input  logic [DataWidth-1:0] cd_data_i,
    input  logic                 cd_last_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [4:0]           rsp_resp_o,
    output logic [LineWidth-1:0] rsp_data_o,
    output logic                 rsp_error_o,
    output logic                 busy_o
);

    localparam int CdBeats = LineWidth / DataWidth;
    localparam int OffBits = $clog2(LineWidth / 8);
    localparam int BeatW   = $clog2(CdBeats);
    localparam int TmoW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [BeatW-1:0]     LastBeat = BeatW'(CdBeats - 1);
    localparam logic [AddrWidth-1:0] OffMask  = {{(AddrWidth-OffBits){1'b0}}, {OffBits{1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND_AC = 3'd1,
        ST_WAIT_CR = 3'd2,
        ST_RECV_CD = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_req_ready;
    logic                  r_ac_valid;
    logic                  r_cr_ready;
    logic                  r_cd_ready;
    logic                  r_rsp_valid;
    logic                  r_busy;
    logic [AddrWidth-1:0]  r_ac_addr;
    logic [3:0]            r_ac_snoop;
    logic [4:0]            r_rsp_resp;
    logic [LineWidth-1:0]  r_rsp_data;
    logic                  r_rsp_error;
    logic [BeatW-1:0]      r_beat_cnt;
    logic [TmoW-1:0]       r_tmo_cnt;

    logic w_req_hs;
    logic w_ac_hs;
    logic w_cr_hs;
    logic w_cd_hs;
    logic w_rsp_hs;
    logic w_tmo_hit;
    logic w_cd_last_bad;

    function automatic logic [AddrWidth-1:0] line_align(input logic [AddrWidth-1:0] addr);
        line_align = addr & ~OffMask;
    endfunction

    // Handshake strobes use the registered ready/valid flags, so nothing is accepted during reset.
    assign w_req_hs  = r_req_ready & req_valid_i;
    assign w_ac_hs   = r_ac_valid & ac_ready_i;
    assign w_cr_hs   = r_cr_ready & cr_valid_i;
    assign w_cd_hs   = r_cd_ready & cd_valid_i;
    assign w_rsp_hs  = r_rsp_valid & rsp_ready_i;
    assign w_tmo_hit = (TimeoutCycles > 0) && ((int'(r_tmo_cnt) + 1) >= TimeoutCycles);
    assign w_cd_last_bad = (r_beat_cnt == LastBeat) ? ~cd_last_i : cd_last_i;

    // Next-state logic for the snoop sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_hs) w_state_nxt = ST_SEND_AC;
                else          w_state_nxt = ST_IDLE;
            end
            ST_SEND_AC: begin
                if (w_ac_hs) w_state_nxt = ST_WAIT_CR;
                else         w_state_nxt = ST_SEND_AC;
            end
            ST_WAIT_CR: begin
                if (w_cr_hs)        w_state_nxt = cr_resp_i[0] ? ST_RECV_CD : ST_RESP;
                else if (w_tmo_hit) w_state_nxt = ST_RESP;
                else                w_state_nxt = ST_WAIT_CR;
            end
            ST_RECV_CD: begin
                if (w_cd_hs)        w_state_nxt = (r_beat_cnt == LastBeat) ? ST_RESP : ST_RECV_CD;
                else if (w_tmo_hit) w_state_nxt = ST_RESP;
                else                w_state_nxt = ST_RECV_CD;
            end
            ST_RESP: begin
                if (w_rsp_hs) w_state_nxt = ST_IDLE;
                else          w_state_nxt = ST_RESP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus handshake flags decoded from the next state so they are registered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_ac_valid  <= 1'b0;
            r_cr_ready  <= 1'b0;
            r_cd_ready  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_ac_valid  <= (w_state_nxt == ST_SEND_AC);
            r_cr_ready  <= (w_state_nxt == ST_WAIT_CR);
            r_cd_ready  <= (w_state_nxt == ST_RECV_CD);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Command capture, CR/CD collection, beat and timeout counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ac_addr   <= '0;
            r_ac_snoop  <= 4'd0;
            r_rsp_resp  <= 5'd0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_beat_cnt  <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_hs) begin
                        r_ac_addr   <= line_align(req_addr_i);
                        r_ac_snoop  <= req_snoop_i;
                        r_rsp_resp  <= 5'd0;
                        r_rsp_data  <= '0;
                        r_rsp_error <= 1'b0;
                        r_beat_cnt  <= '0;
                        r_tmo_cnt   <= '0;
                    end
                end
                ST_WAIT_CR: begin
                    if (w_cr_hs) begin
                        r_rsp_resp  <= cr_resp_i;
                        r_rsp_error <= r_rsp_error | cr_resp_i[1];
                        r_tmo_cnt   <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
                        if (w_tmo_hit) r_rsp_error <= 1'b1;
                    end
                end
                ST_RECV_CD: begin
                    if (w_cd_hs) begin
                        for (int k = 0; k < CdBeats; k++) begin
                            if (r_beat_cnt == BeatW'(k)) r_rsp_data[k*DataWidth +: DataWidth] <= cd_data_i;
                        end
                        r_beat_cnt  <= r_beat_cnt + BeatW'(1);
                        r_tmo_cnt   <= '0;
                        r_rsp_error <= r_rsp_error | w_cd_last_bad;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
                        if (w_tmo_hit) r_rsp_error <= 1'b1;
                    end
                end
                default: begin
                    r_tmo_cnt <= r_tmo_cnt;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign ac_valid_o  = r_ac_valid;
    assign ac_addr_o   = r_ac_addr;
    assign ac_snoop_o  = r_ac_snoop;
    assign ac_prot_o   = 3'b000;
    assign cr_ready_o  = r_cr_ready;
    assign cd_ready_o  = r_cd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_resp_o  = r_rsp_resp;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_error_o = r_rsp_error;
    assign busy_o      = r_busy;

endmodule
